// File: rtl/conway_pkg.sv
// Shared definitions for the Game-of-Life generation controller: sequencer states,
// host register offsets and STATUS/CTRL bit positions.
package conway_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitFrame = 3'd1,
    StStart     = 3'd2,
    StBusy      = 3'd3,
    StSwap      = 3'd4
  } gen_state_e;

  localparam logic [2:0] RegCtrl     = 3'd0;
  localparam logic [2:0] RegStatus   = 3'd1;
  localparam logic [2:0] RegGenCount = 3'd2;
  localparam logic [2:0] RegPattern  = 3'd3;
  localparam logic [2:0] RegLoadPtr  = 3'd4;
  localparam logic [2:0] RegIrqAck   = 3'd5;

  localparam int unsigned CtrlRunBit   = 0;
  localparam int unsigned CtrlStepBit  = 1;
  localparam int unsigned CtrlIrqEnBit = 2;

  localparam int unsigned StatStateLsb      = 0;
  localparam int unsigned StatDispSelBit    = 3;
  localparam int unsigned StatErrTimeoutBit = 4;
  localparam int unsigned StatErrDropBit    = 5;

  localparam int unsigned PatternW = 20;

endpackage

// File: rtl/conway_gen_regs.sv
// Host register block: CTRL/step flag, GEN_COUNT, pattern loader, irq and error flags,
// plus registered read-data mux.
module conway_gen_regs
  import conway_pkg::*;
#(
  parameter int unsigned AddrW = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cs_i,
  input  logic                wr_i,
  input  logic                rd_i,
  input  logic [2:0]          addr_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  input  logic [2:0]          state_i,
  input  logic                disp_sel_i,
  input  logic                step_clr_i,
  input  logic                gen_inc_i,
  input  logic                timeout_i,
  output logic                run_o,
  output logic                step_o,
  output logic                load_wr_o,
  output logic [AddrW-1:0]    load_addr_o,
  output logic [PatternW-1:0] load_data_o,
  output logic                irq_o
);

  logic wr_en, rd_en, in_idle;
  logic wr_ctrl, wr_gen, wr_pat, wr_ptr, wr_ack;
  logic unused_wdata;

  logic                run_q, run_d, irq_en_q, irq_en_d, step_q, step_d;
  logic                irq_q, irq_d, err_drop_q, err_drop_d, err_to_q, err_to_d;
  logic [AddrW-1:0]    ptr_q, ptr_d, load_addr_q, load_addr_d;
  logic [PatternW-1:0] load_data_q, load_data_d;
  logic                load_wr_q, load_wr_d;
  logic [31:0]         gen_cnt_q, gen_cnt_d, rdata_q, rdata_d;

  assign wr_en   = cs_i && wr_i;
  assign rd_en   = cs_i && rd_i;
  assign in_idle = (state_i == StIdle);
  assign wr_ctrl = wr_en && (addr_i == RegCtrl);
  assign wr_gen  = wr_en && (addr_i == RegGenCount);
  assign wr_pat  = wr_en && (addr_i == RegPattern);
  assign wr_ptr  = wr_en && (addr_i == RegLoadPtr);
  assign wr_ack  = wr_en && (addr_i == RegIrqAck);
  assign unused_wdata = ^wdata_i;

  always_comb begin
    run_d       = run_q;
    irq_en_d    = irq_en_q;
    step_d      = step_q;
    irq_d       = irq_q;
    err_drop_d  = err_drop_q;
    err_to_d    = err_to_q;
    ptr_d       = ptr_q;
    load_wr_d   = 1'b0;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;
    gen_cnt_d   = gen_cnt_q;
    rdata_d     = rdata_q;

    if (wr_ctrl) begin
      run_d    = wdata_i[CtrlRunBit];
      irq_en_d = wdata_i[CtrlIrqEnBit];
    end
    // A fresh step request wins over the clear on START entry.
    if (step_clr_i) step_d = 1'b0;
    if (wr_ctrl && wdata_i[CtrlStepBit]) step_d = 1'b1;

    if (wr_ptr) ptr_d = wdata_i[AddrW-1:0];
    if (wr_pat) begin
      if (in_idle) begin
        load_wr_d   = 1'b1;
        load_addr_d = ptr_q;
        load_data_d = wdata_i[PatternW-1:0];
        ptr_d       = ptr_q + AddrW'(1);
      end else begin
        err_drop_d  = 1'b1;
      end
    end

    if (gen_inc_i) gen_cnt_d = gen_cnt_q + 32'd1;
    if (wr_gen)    gen_cnt_d = '0;

    if (wr_ack) begin
      irq_d    = 1'b0;
      err_to_d = 1'b0;
    end
    if (gen_inc_i && irq_en_q) irq_d = 1'b1;
    if (timeout_i) err_to_d = 1'b1;

    if (rd_en) begin
      rdata_d = '0;
      case (addr_i)
        RegCtrl: begin
          rdata_d[CtrlRunBit]   = run_q;
          rdata_d[CtrlStepBit]  = step_q;
          rdata_d[CtrlIrqEnBit] = irq_en_q;
        end
        RegStatus: begin
          rdata_d[StatStateLsb +: 3]    = state_i;
          rdata_d[StatDispSelBit]       = disp_sel_i;
          rdata_d[StatErrTimeoutBit]    = err_to_q;
          rdata_d[StatErrDropBit]       = err_drop_q;
        end
        RegGenCount: rdata_d = gen_cnt_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      run_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      step_q      <= 1'b0;
      irq_q       <= 1'b0;
      err_drop_q  <= 1'b0;
      err_to_q    <= 1'b0;
      ptr_q       <= '0;
      load_wr_q   <= 1'b0;
      load_addr_q <= '0;
      load_data_q <= '0;
      gen_cnt_q   <= '0;
      rdata_q     <= '0;
    end else begin
      run_q       <= run_d;
      irq_en_q    <= irq_en_d;
      step_q      <= step_d;
      irq_q       <= irq_d;
      err_drop_q  <= err_drop_d;
      err_to_q    <= err_to_d;
      ptr_q       <= ptr_d;
      load_wr_q   <= load_wr_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
      gen_cnt_q   <= gen_cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign run_o       = run_q;
  assign step_o      = step_q;
  assign load_wr_o   = load_wr_q;
  assign load_addr_o = load_addr_q;
  assign load_data_o = load_data_q;
  assign irq_o       = irq_q;

endmodule

// File: rtl/conway_gen_ctrl.sv
// Generation sequencer: paces the accelerator against VGA frames, swaps the displayed
// buffer at frame boundaries and guards each generation with a watchdog.
module conway_gen_ctrl
  import conway_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [2:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              frame_end,
  output logic              eng_start,
  input  logic              eng_done,
  output logic              eng_en,
  output logic              disp_sel,
  output logic              load_wr,
  output logic [ADDR_W-1:0] load_addr,
  output logic [19:0]       load_data,
  output logic              irq
);

  localparam int unsigned    WdW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  gen_state_e     state_q, state_d;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           disp_sel_q, disp_sel_d;
  logic           run, step_pend, go, gen_inc, timeout, step_clr;

  assign go = run || step_pend;

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    disp_sel_d = disp_sel_q;
    gen_inc    = 1'b0;
    timeout    = 1'b0;
    unique case (state_q)
      StIdle: if (go) state_d = StWaitFrame;
      StWaitFrame: begin
        if (!go)           state_d = StIdle;
        else if (frame_end) state_d = StStart;
      end
      StStart: begin
        wdog_d  = '0;
        state_d = StBusy;
      end
      // frame_end is deliberately ignored here: the swap needs a later frame boundary.
      StBusy: begin
        if (eng_done) begin
          state_d = StSwap;
        end else if (wdog_q == WdLast) begin
          state_d = StIdle;
          timeout = 1'b1;
        end else begin
          wdog_d  = wdog_q + WdW'(1);
        end
      end
      StSwap: begin
        if (frame_end) begin
          disp_sel_d = ~disp_sel_q;
          gen_inc    = 1'b1;
          state_d    = go ? StStart : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign step_clr = (state_d == StStart) && (state_q != StStart);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wdog_q     <= '0;
      disp_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      disp_sel_q <= disp_sel_d;
    end
  end

  assign eng_start = (state_q == StStart);
  assign eng_en    = (state_q != StIdle);
  assign disp_sel  = disp_sel_q;

  conway_gen_regs #(
    .AddrW (ADDR_W)
  ) u_regs (
    .clk_i       (clk),
    .reset_i     (reset),
    .cs_i        (chipselect),
    .wr_i        (write),
    .rd_i        (read),
    .addr_i      (address),
    .wdata_i     (writedata),
    .rdata_o     (readdata),
    .state_i     (state_q),
    .disp_sel_i  (disp_sel_q),
    .step_clr_i  (step_clr),
    .gen_inc_i   (gen_inc),
    .timeout_i   (timeout),
    .run_o       (run),
    .step_o      (step_pend),
    .load_wr_o   (load_wr),
    .load_addr_o (load_addr),
    .load_data_o (load_data),
    .irq_o       (irq)
  );

endmodule
